// File: rtl/id_ex_register_pkg.sv
// Shared pipeline-register definitions: default widths, the single-bit
// control-flag bundle and the bubble record that every stage register
// loads when it has to squash its contents.
package id_ex_register_pkg;

  // Default field widths shared by all pipeline registers
  localparam int DATA_WIDTH_DEF       = 32;
  localparam int RESULTSRC_WIDTH_DEF  = 2;
  localparam int ALUCONTROL_WIDTH_DEF = 4;
  localparam int REG_ADDR_WIDTH_DEF   = 5;
  localparam int FUNCT3_WIDTH_DEF     = 3;
  localparam int CNT_WIDTH_DEF        = 16;

  // Fixed-width decode fields
  localparam int ALUSRCA_WIDTH    = 2;
  localparam int WRITE_TYPE_WIDTH = 2;

  // Control bits whose assertion has an architectural side effect
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic jump;
    logic branch;
    logic alu_src_b;
    logic pc_jal_src;
  } ctrl_flags_t;

  localparam int CTRL_FLAGS_WIDTH = $bits(ctrl_flags_t);

  // An inert control bundle: nothing is written, nothing redirects the PC
  localparam ctrl_flags_t BUBBLE_FLAGS = '0;

  // A bubble is written on flush (even while stalled) or when an
  // unstalled stage receives an empty decode slot.
  function automatic logic is_bubble(input logic valid_d,
                                     input logic stall,
                                     input logic flush);
    return flush | (~stall & ~valid_d);
  endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: decode-side inputs (*_D), stage control,
// and the registered execute-side view (*_E) plus the bubble counter.
interface id_ex_register_if
  import id_ex_register_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int RESULTSRC_WIDTH  = RESULTSRC_WIDTH_DEF,
  parameter int ALUCONTROL_WIDTH = ALUCONTROL_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
  parameter int FUNCT3_WIDTH     = FUNCT3_WIDTH_DEF,
  parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) ();

  // Decode-side control
  logic                        RegWrite_D;
  logic                        MemWrite_D;
  logic                        Jump_D;
  logic                        Branch_D;
  logic                        ALUSrcB_D;
  logic                        PCJalSrc_D;
  logic [RESULTSRC_WIDTH-1:0]  ResultSrc_D;
  logic [ALUCONTROL_WIDTH-1:0] ALUControl_D;
  logic [ALUSRCA_WIDTH-1:0]    ALUSrcA_D;
  logic [WRITE_TYPE_WIDTH-1:0] write_type_D;

  // Decode-side datapath and register indices
  logic [DATA_WIDTH-1:0]       RD1_D;
  logic [DATA_WIDTH-1:0]       RD2_D;
  logic [DATA_WIDTH-1:0]       PC_D;
  logic [DATA_WIDTH-1:0]       ImmExt_D;
  logic [DATA_WIDTH-1:0]       PCPlus4_D;
  logic [REG_ADDR_WIDTH-1:0]   Rs1_D;
  logic [REG_ADDR_WIDTH-1:0]   Rs2_D;
  logic [REG_ADDR_WIDTH-1:0]   Rd_D;
  logic [FUNCT3_WIDTH-1:0]     funct3_D;
  logic                        valid_D;

  // Stage control from the hazard unit
  logic                        stall_E;
  logic                        flush_E;

  // Execute-side registered view
  logic                        RegWrite_E;
  logic                        MemWrite_E;
  logic                        Jump_E;
  logic                        Branch_E;
  logic                        ALUSrcB_E;
  logic                        PCJalSrc_E;
  logic [RESULTSRC_WIDTH-1:0]  ResultSrc_E;
  logic [ALUCONTROL_WIDTH-1:0] ALUControl_E;
  logic [ALUSRCA_WIDTH-1:0]    ALUSrcA_E;
  logic [WRITE_TYPE_WIDTH-1:0] write_type_E;
  logic [DATA_WIDTH-1:0]       RD1_E;
  logic [DATA_WIDTH-1:0]       RD2_E;
  logic [DATA_WIDTH-1:0]       PC_E;
  logic [DATA_WIDTH-1:0]       ImmExt_E;
  logic [DATA_WIDTH-1:0]       PCPlus4_E;
  logic [REG_ADDR_WIDTH-1:0]   Rs1_E;
  logic [REG_ADDR_WIDTH-1:0]   Rs2_E;
  logic [REG_ADDR_WIDTH-1:0]   Rd_E;
  logic [FUNCT3_WIDTH-1:0]     funct3_E;
  logic                        valid_E;
  logic [CNT_WIDTH-1:0]        bubble_count;

  // Decode stage / hazard unit side
  modport master (
    output RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrcB_D, PCJalSrc_D,
           ResultSrc_D, ALUControl_D, ALUSrcA_D, write_type_D,
           RD1_D, RD2_D, PC_D, ImmExt_D, PCPlus4_D,
           Rs1_D, Rs2_D, Rd_D, funct3_D, valid_D,
           stall_E, flush_E,
    input  RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrcB_E, PCJalSrc_E,
           ResultSrc_E, ALUControl_E, ALUSrcA_E, write_type_E,
           RD1_E, RD2_E, PC_E, ImmExt_E, PCPlus4_E,
           Rs1_E, Rs2_E, Rd_E, funct3_E, valid_E, bubble_count
  );

  // Pipeline register side
  modport slave (
    input  RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUSrcB_D, PCJalSrc_D,
           ResultSrc_D, ALUControl_D, ALUSrcA_D, write_type_D,
           RD1_D, RD2_D, PC_D, ImmExt_D, PCPlus4_D,
           Rs1_D, Rs2_D, Rd_D, funct3_D, valid_D,
           stall_E, flush_E,
    output RegWrite_E, MemWrite_E, Jump_E, Branch_E, ALUSrcB_E, PCJalSrc_E,
           ResultSrc_E, ALUControl_E, ALUSrcA_E, write_type_E,
           RD1_E, RD2_E, PC_E, ImmExt_E, PCPlus4_E,
           Rs1_E, Rs2_E, Rd_E, funct3_E, valid_E, bubble_count
  );

endinterface

// File: rtl/id_ex_register_pipe_reg_en_clr.sv
// Generic pipeline register slice: async active-low reset to zero,
// synchronous clear to CLR_VALUE that wins over the enable, and a hold
// when the enable is low.
module pipe_reg_en_clr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear beats enable so a flush lands even while the stage is stalled
  // NOTE: state uses non-blocking assignment so every flop samples the
  // pre-edge values regardless of block evaluation order.
  // NOTE: reset sits in the sensitivity list so outputs clear at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= CLR_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register. Captures the decode bundle each cycle, holds
// it on stall, and writes an all-zero bubble on flush or on an empty
// decode slot. A saturating counter tracks how many bubbles were written.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int RESULTSRC_WIDTH  = RESULTSRC_WIDTH_DEF,
  parameter int ALUCONTROL_WIDTH = ALUCONTROL_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF,
  parameter int FUNCT3_WIDTH     = FUNCT3_WIDTH_DEF,
  parameter int CNT_WIDTH        = CNT_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_register_if.slave   bus
);

  localparam int CTRL_W = RESULTSRC_WIDTH + ALUCONTROL_WIDTH
                        + ALUSRCA_WIDTH + WRITE_TYPE_WIDTH;
  localparam int DATA_W = 5 * DATA_WIDTH;
  localparam int REGS_W = 3 * REG_ADDR_WIDTH + FUNCT3_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic              w_bubble;
  logic              w_en;
  ctrl_flags_t       w_flags_d;
  ctrl_flags_t       w_flags_e;
  logic [CTRL_W-1:0] w_ctrl_d;
  logic [CTRL_W-1:0] w_ctrl_e;
  logic [DATA_W-1:0] w_data_d;
  logic [DATA_W-1:0] w_data_e;
  logic [REGS_W-1:0] w_regs_d;
  logic [REGS_W-1:0] w_regs_e;
  logic              w_valid_e;
  logic [CNT_WIDTH-1:0] r_bubble_count;

  // Stage control shared by every field group
  assign w_bubble = is_bubble(bus.valid_D, bus.stall_E, bus.flush_E);
  assign w_en     = ~bus.stall_E;

  // Pack decode-side fields into their groups
  assign w_flags_d = '{
    reg_write:  bus.RegWrite_D,
    mem_write:  bus.MemWrite_D,
    jump:       bus.Jump_D,
    branch:     bus.Branch_D,
    alu_src_b:  bus.ALUSrcB_D,
    pc_jal_src: bus.PCJalSrc_D
  };
  assign w_ctrl_d = {bus.ResultSrc_D, bus.ALUControl_D,
                     bus.ALUSrcA_D, bus.write_type_D};
  assign w_data_d = {bus.RD1_D, bus.RD2_D, bus.PC_D,
                     bus.ImmExt_D, bus.PCPlus4_D};
  assign w_regs_d = {bus.Rs1_D, bus.Rs2_D, bus.Rd_D, bus.funct3_D};

  // Side-effecting control flags; the clear value is the inert bundle
  pipe_reg_en_clr #(
    .WIDTH     (CTRL_FLAGS_WIDTH),
    .CLR_VALUE (BUBBLE_FLAGS)
  ) u_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_clr (w_bubble),
    .i_d   (w_flags_d),
    .o_q   (w_flags_e)
  );

  // Multi-bit control fields
  pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_clr (w_bubble),
    .i_d   (w_ctrl_d),
    .o_q   (w_ctrl_e)
  );

  // Operands, PC values and immediate
  pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_clr (w_bubble),
    .i_d   (w_data_d),
    .o_q   (w_data_e)
  );

  // Register indices and funct3
  pipe_reg_en_clr #(.WIDTH(REGS_W)) u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_clr (w_bubble),
    .i_d   (w_regs_d),
    .o_q   (w_regs_e)
  );

  // Instruction-valid marker
  pipe_reg_en_clr #(.WIDTH(1)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_clr (w_bubble),
    .i_d   (bus.valid_D),
    .o_q   (w_valid_e)
  );

  // Count written bubbles, sticking at the all-ones value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= '0;
    end else if (w_bubble && (r_bubble_count != CNT_MAX)) begin
      r_bubble_count <= r_bubble_count + CNT_WIDTH'(1);
    end
  end

  // Execute-side outputs come straight from the flops
  assign bus.RegWrite_E = w_flags_e.reg_write;
  assign bus.MemWrite_E = w_flags_e.mem_write;
  assign bus.Jump_E     = w_flags_e.jump;
  assign bus.Branch_E   = w_flags_e.branch;
  assign bus.ALUSrcB_E  = w_flags_e.alu_src_b;
  assign bus.PCJalSrc_E = w_flags_e.pc_jal_src;
  assign {bus.ResultSrc_E, bus.ALUControl_E,
          bus.ALUSrcA_E, bus.write_type_E} = w_ctrl_e;
  assign {bus.RD1_E, bus.RD2_E, bus.PC_E,
          bus.ImmExt_E, bus.PCPlus4_E} = w_data_e;
  assign {bus.Rs1_E, bus.Rs2_E, bus.Rd_E, bus.funct3_E} = w_regs_e;
  assign bus.valid_E      = w_valid_e;
  assign bus.bubble_count = r_bubble_count;

endmodule
